// File: rtl/msb_pkg.sv
// msb_pkg: shared constants and FSM state type for the
// MSB position decoder slice (position width, count ceiling).
package msb_pkg;

  localparam int POS_W = 8;

  localparam logic [POS_W-1:0] CNT_MAX = 8'hFF;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } msb_dec_state_t;

endpackage

// File: rtl/msb_pos_dec.sv
// msb_pos_dec: combinational 1-based position -> N-bit mask.
// Ports: pos (0 = no bit), mask (N bits), oob (pos > N).
// Build option MSB_DEC_THERMO_EN: mask is bits [pos-1:0]
// instead of the one-hot bit pos-1.
module msb_pos_dec
  import msb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [POS_W-1:0] pos,
  output logic [N-1:0]     mask,
  output logic             oob
);

  localparam logic [POS_W-1:0] NP = POS_W'(N);

  assign oob = (pos > NP);

  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
`ifdef MSB_DEC_THERMO_EN
      mask[i] = (pos > POS_W'(i)) && !oob;
`else
      mask[i] = (pos == POS_W'(i + 1));
`endif
    end
  end

endmodule

// File: rtl/msb_word_decoder.sv
// msb_word_decoder: OR-accumulates decoded positions into a
// word; emits word/count/err on a valid/ready port at in_last.
// Ports: clk, rst (sync, high), in_pos/in_last/in_valid/in_ready,
// out_word/out_count/out_err/out_valid/out_ready.
// Build option MSB_DEC_THERMO_EN selects thermometer decode.
module msb_word_decoder
  import msb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] in_pos,
  input  logic             in_last,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_word,
  output logic [POS_W-1:0] out_count,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);

  msb_dec_state_t state;

  logic [N-1:0]     acc;
  logic [POS_W-1:0] cnt;
  logic             err;

  logic [N-1:0]     mask;
  logic             oob;
  logic [N-1:0]     acc_nx;
  logic [POS_W-1:0] cnt_nx;
  logic             err_nx;

  msb_pos_dec #(
    .N (N)
  ) u_dec (
    .pos  (in_pos),
    .mask (mask),
    .oob  (oob)
  );

  assign acc_nx = acc | mask;
  assign err_nx = err | oob;
  assign cnt_nx = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

  assign in_ready  = (state == ACC);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      out_word  <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
    end else begin
      unique case (state)
        ACC: begin
          if (in_valid) begin
            acc <= acc_nx;
            cnt <= cnt_nx;
            err <= err_nx;
            if (in_last) begin
              out_word  <= acc_nx;
              out_count <= cnt_nx;
              out_err   <= err_nx;
              state     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            acc   <= '0;
            cnt   <= '0;
            err   <= 1'b0;
            state <= ACC;
          end
        end
        default: state <= ACC;
      endcase
    end
  end

endmodule

// File: tb/tb_msb_word_decoder.sv
// tb_msb_word_decoder: directed vector table plus hand-written
// sequences for backpressure, reset and count saturation.
module tb_msb_word_decoder;

`ifdef MSB_DEC_THERMO_EN
  localparam bit TH = 1'b1;
`else
  localparam bit TH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_pos;
  logic        in_last;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_word;
  logic [7:0]  out_count;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  msb_word_decoder #(
    .N (32)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_pos    (in_pos),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_count (out_count),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  typedef struct {
    int             n;
    logic [7:0][7:0] p;
    logic [31:0]    w;
    logic [7:0]     c;
    logic           e;
  } vec_t;

  vec_t v [8];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic [7:0] p,
                      input logic l);
    in_pos   = p;
    in_last  = l;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic take(input string nm,
                      input logic [31:0] w,
                      input logic [7:0] c,
                      input logic e);
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".word"}, out_word, w);
    chk({nm, ".count"}, 32'(out_count), 32'(c));
    chk({nm, ".err"}, 32'(out_err), 32'(e));
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({nm, ".rdy_after"}, 32'(in_ready), 32'd1);
    chk({nm, ".vld_after"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [31:0] w;

    v[0].n = 1; v[0].p = {56'd0, 8'd32};
    v[0].w = TH ? 32'hFFFF_FFFF : 32'h8000_0000;
    v[0].c = 8'd1; v[0].e = 1'b0;

    v[1].n = 5;
    v[1].p = {24'd0, 8'd17, 8'd0, 8'd9, 8'd9, 8'd1};
    v[1].w = TH ? 32'h0001_FFFF : 32'h0001_0101;
    v[1].c = 8'd5; v[1].e = 1'b0;

    v[2].n = 2; v[2].p = {48'd0, 8'd40, 8'd5};
    v[2].w = TH ? 32'h1F : 32'h10;
    v[2].c = 8'd2; v[2].e = 1'b1;

    v[3].n = 1; v[3].p = {56'd0, 8'd3};
    v[3].w = TH ? 32'h7 : 32'h4;
    v[3].c = 8'd1; v[3].e = 1'b0;

    v[4].n = 3; v[4].p = 64'd0;
    v[4].w = 32'h0;
    v[4].c = 8'd3; v[4].e = 1'b0;

    v[5].n = 1; v[5].p = {56'd0, 8'd33};
    v[5].w = 32'h0;
    v[5].c = 8'd1; v[5].e = 1'b1;

    v[6].n = 2; v[6].p = {48'd0, 8'd255, 8'd2};
    v[6].w = TH ? 32'h3 : 32'h2;
    v[6].c = 8'd2; v[6].e = 1'b1;

    v[7].n = 2; v[7].p = {48'd0, 8'd1, 8'd32};
    v[7].w = TH ? 32'hFFFF_FFFF : 32'h8000_0001;
    v[7].c = 8'd2; v[7].e = 1'b0;

    rst       = 1'b1;
    in_pos    = '0;
    in_last   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.word", out_word, 32'h0);
    chk("reset.count", 32'(out_count), 32'd0);
    chk("reset.err", 32'(out_err), 32'd0);
    chk("reset.valid", 32'(out_valid), 32'd0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      for (int b = 0; b < v[i].n; b++)
        beat(v[i].p[b], b == v[i].n - 1);
      take($sformatf("vec%0d", i),
           v[i].w, v[i].c, v[i].e);
    end

    // backpressure with a stray beat offered in HOLD
    w = TH ? 32'h7F : 32'h40;
    beat(8'd7, 1'b1);
    in_pos   = 8'd1;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d.word", k), out_word, w);
      chk($sformatf("bp%0d.rdy", k),
          32'(in_ready), 32'd0);
      chk($sformatf("bp%0d.vld", k),
          32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    take("bp", w, 8'd1, 1'b0);
    beat(8'd2, 1'b1);
    take("bp_next", TH ? 32'h3 : 32'h2, 8'd1, 1'b0);

    // reset mid-word
    beat(8'd2, 1'b0);
    beat(8'd4, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_mid.word", out_word, 32'h0);
    chk("rst_mid.rdy", 32'(in_ready), 32'd1);
    beat(8'd1, 1'b1);
    take("rst_mid", 32'h1, 8'd1, 1'b0);

    // reset while holding, with out_ready also high
    beat(8'd9, 1'b1);
    rst       = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b0;
    chk("rst_hold.vld", 32'(out_valid), 32'd0);
    chk("rst_hold.word", out_word, 32'h0);
    chk("rst_hold.count", 32'(out_count), 32'd0);
    chk("rst_hold.rdy", 32'(in_ready), 32'd1);

    // count saturation
    for (int k = 0; k < 300; k++)
      beat(8'd1, 1'b0);
    beat(8'd1, 1'b1);
    take("sat", 32'h1, 8'd255, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
